sdf_ifft_stage: RTL

SDF_IFFT_STAGE -- requirements
Module: sdf_ifft_stage

---
 rtl/sdf_ifft_stage_pkg.sv | 12 +
 rtl/butterfly.sv | 21 ++
 rtl/sdf_delay_line.sv | 41 ++++
 rtl/sdf_ifft_stage.sv | 110 +++++++++++
 4 files changed

// File: rtl/sdf_ifft_stage_pkg.sv
// Shared FFT constants and helpers for the single-path delay-feedback stages.
package sdf_ifft_stage_pkg;

  localparam int FFT_DATA_WIDTH = 16;
  localparam int FFT_SIZE       = 128;

  // The stage counter spans one full butterfly span: DELAY fill plus DELAY butterfly samples.
  function automatic int cnt_width(input int delay);
    return $clog2(2 * delay);
  endfunction

endpackage

// File: rtl/butterfly.sv
// Combinational radix-2 butterfly: sum = a + b, diff = a - b per component.
// Zero latency, no flow control; the caller widens operands so nothing wraps.
module butterfly #(
  parameter int W = 17
) (
  input  logic [W-1:0] a_r,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_r,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_r,
  output logic [W-1:0] sum_i,
  output logic [W-1:0] diff_r,
  output logic [W-1:0] diff_i
);

  assign sum_r  = a_r + b_r;
  assign sum_i  = a_i + b_i;
  assign diff_r = a_r - b_r;
  assign diff_i = a_i - b_i;

endmodule

// File: rtl/sdf_delay_line.sv
// DEPTH-deep complex shift register; head is the oldest entry.
// Shifts only when en is high, otherwise holds; storage is deliberately not reset.
module sdf_delay_line import sdf_ifft_stage_pkg::*; #(
  parameter int W     = FFT_DATA_WIDTH,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] in_r,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] head_r,
  output logic [W-1:0] head_i
);

  logic [W-1:0] re_q [DEPTH];
  logic [W-1:0] re_d [DEPTH];
  logic [W-1:0] im_q [DEPTH];
  logic [W-1:0] im_d [DEPTH];

  always_comb begin
    re_d = re_q;
    im_d = im_q;
    if (en) begin
      re_d[0] = in_r;
      im_d[0] = in_i;
      for (int k = 1; k < DEPTH; k++) begin
        re_d[k] = re_q[k-1];
        im_d[k] = im_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    re_q <= re_d;
    im_q <= im_d;
  end

  assign head_r = re_q[DEPTH-1];
  assign head_i = im_q[DEPTH-1];

endmodule

// File: rtl/sdf_ifft_stage.sv
// Radix-2 single-path delay-feedback IFFT stage (no twiddles), 1/2 scaling per stage.
// Latency 1 cycle; in_valid low stalls counter and delay line, outputs hold.
module sdf_ifft_stage import sdf_ifft_stage_pkg::*; #(
  parameter int DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int DELAY      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_i,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_r,
  output logic [DATA_WIDTH-1:0] out_i
);

  localparam int CW = cnt_width(DELAY);
  localparam int WW = DATA_WIDTH + 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  primed_q, primed_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_r_q, out_r_d;
  logic [DATA_WIDTH-1:0] out_i_q, out_i_d;

  logic [DATA_WIDTH-1:0] head_r, head_i;
  logic [DATA_WIDTH-1:0] dl_in_r, dl_in_i;
  logic [WW-1:0]         a_r, a_i, b_r, b_i;
  logic [WW-1:0]         sum_r, sum_i, diff_r, diff_i;
  logic [DATA_WIDTH-1:0] sum_sc_r, sum_sc_i, diff_sc_r, diff_sc_i;
  logic                  is_bfly;

  // 2*DELAY is a power of two, so the counter MSB is exactly "cnt >= DELAY".
  assign is_bfly = cnt_q[CW-1];

  assign a_r = {head_r[DATA_WIDTH-1], head_r};
  assign a_i = {head_i[DATA_WIDTH-1], head_i};
  assign b_r = {in_r[DATA_WIDTH-1], in_r};
  assign b_i = {in_i[DATA_WIDTH-1], in_i};

  butterfly #(.W(WW)) u_bfly (
    .a_r    (a_r),
    .a_i    (a_i),
    .b_r    (b_r),
    .b_i    (b_i),
    .sum_r  (sum_r),
    .sum_i  (sum_i),
    .diff_r (diff_r),
    .diff_i (diff_i)
  );

  // Arithmetic shift of the widened result floors and always fits back in DATA_WIDTH.
  assign sum_sc_r  = DATA_WIDTH'($signed(sum_r) >>> 1);
  assign sum_sc_i  = DATA_WIDTH'($signed(sum_i) >>> 1);
  assign diff_sc_r = DATA_WIDTH'($signed(diff_r) >>> 1);
  assign diff_sc_i = DATA_WIDTH'($signed(diff_i) >>> 1);

  sdf_delay_line #(.W(DATA_WIDTH), .DEPTH(DELAY)) u_dl (
    .clk    (clk),
    .en     (in_valid),
    .in_r   (dl_in_r),
    .in_i   (dl_in_i),
    .head_r (head_r),
    .head_i (head_i)
  );

  always_comb begin
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    out_valid_d = in_valid & (is_bfly | primed_q);
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    dl_in_r     = is_bfly ? diff_sc_r : in_r;
    dl_in_i     = is_bfly ? diff_sc_i : in_i;

    if (in_valid) begin
      cnt_d = cnt_q + CW'(1);
      if (is_bfly) begin
        primed_d = 1'b1;
      end
    end

    // FILL emits the previous frame's stored difference; BFLY emits the scaled sum.
    if (out_valid_d) begin
      out_r_d = is_bfly ? sum_sc_r : head_r;
      out_i_d = is_bfly ? sum_sc_i : head_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;

endmodule
